// File: rtl/lm_sm_sequencer_if.sv
// Handshake bundle between the control FSM (master) and the LM/SM register-list sequencer (slave).
interface lm_sm_sequencer_if;
  logic       start;
  logic [7:0] imm;
  logic       advance;
  logic       flush;
  logic [2:0] reg_sel;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] count;

  modport master (
    output start, imm, advance, flush,
    input  reg_sel, valid, busy, done, count
  );

  modport slave (
    input  start, imm, advance, flush,
    output reg_sel, valid, busy, done, count
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load/store-multiple register-list sequencer: walks an 8-bit mask and emits one register index per transfer.
// Optional build macro LM_SEQ_DESCEND_EN selects highest-set-bit-first ordering instead of lowest-first.
module lm_sm_sequencer (
  input  logic              clk,
  input  logic              reset,
  lm_sm_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] pending, pending_nxt, pending_clr;
  logic [3:0] count, count_nxt;
  logic [2:0] enc;

  // The loop overwrites on every set bit, so the last bit visited wins.
`ifdef LM_SEQ_DESCEND_EN
  function automatic logic [2:0] prio_enc(input logic [7:0] m);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 0; i < 8; i++)
      if (m[i]) res = 3'(i);
    return res;
  endfunction
`else
  function automatic logic [2:0] prio_enc(input logic [7:0] m);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) res = 3'(i);
    return res;
  endfunction
`endif

  assign enc         = prio_enc(pending);
  assign pending_clr = pending & ~(8'd1 << enc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= 8'd0;
      count   <= 4'd0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      count   <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    count_nxt   = count;
    if (bus.flush) begin
      state_nxt   = IDLE;
      pending_nxt = 8'd0;
      count_nxt   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            pending_nxt = bus.imm;
            count_nxt   = 4'd0;
            state_nxt   = (bus.imm != 8'd0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (bus.advance) begin
            pending_nxt = pending_clr;
            count_nxt   = count + 4'd1;
            if (pending_clr == 8'd0) state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only, so an async reset clears them at once.
  assign bus.valid   = (state == RUN);
  assign bus.reg_sel = bus.valid ? enc : 3'd0;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.count   = count;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed self-checking bench for lm_sm_sequencer (either ordering build).
module tb_lm_sm_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lm_sm_sequencer_if bus ();

  lm_sm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LM_SEQ_DESCEND_EN
  logic [2:0] exp_a5 [4] = '{3'd7, 3'd5, 3'd2, 3'd0};
  logic [2:0] exp_81 [2] = '{3'd7, 3'd0};
  logic [2:0] exp_0f [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
  logic [2:0] exp_ff [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
`else
  logic [2:0] exp_a5 [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
  logic [2:0] exp_81 [2] = '{3'd0, 3'd7};
  logic [2:0] exp_0f [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
  logic [2:0] exp_ff [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.imm = 8'd0; bus.advance = 1'b0; bus.flush = 1'b0;
    step();
    checks++;
    if ({bus.valid, bus.busy, bus.done, bus.reg_sel, bus.count} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got v%b b%b d%b sel%0d cnt%0d want all zero",
               bus.valid, bus.busy, bus.done, bus.reg_sel, bus.count);
    end
    reset = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_ascend();
    bus.imm = 8'b1010_0101; bus.start = 1'b1; bus.advance = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.reg_sel !== exp_a5[i] || bus.count !== 4'(i) || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL ascend_xfer%0d got v%b sel%0d cnt%0d d%b want v1 sel%0d cnt%0d d0",
                 i, bus.valid, bus.reg_sel, bus.count, bus.done, exp_a5[i], i);
      end
      step();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.valid !== 1'b0 || bus.count !== 4'd4) begin
      errors++;
      $display("FAIL ascend_done got d%b b%b v%b cnt%0d want d1 b1 v0 cnt4",
               bus.done, bus.busy, bus.valid, bus.count);
    end
    bus.advance = 1'b0;
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 4'd4 || bus.reg_sel !== 3'd0) begin
      errors++;
      $display("FAIL ascend_idle got d%b b%b cnt%0d sel%0d want d0 b0 cnt4 sel0",
               bus.done, bus.busy, bus.count, bus.reg_sel);
    end
  endtask

  task automatic test_stall();
    bus.imm = 8'h81; bus.start = 1'b1; bus.advance = 1'b0;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.reg_sel !== exp_81[0] || bus.count !== 4'd0) begin
        errors++;
        $display("FAIL stall_hold%0d got v%b sel%0d cnt%0d want v1 sel%0d cnt0",
                 i, bus.valid, bus.reg_sel, bus.count, exp_81[0]);
      end
      if (i < 2) step();
    end
    bus.advance = 1'b1;
    step();
    checks++;
    if (bus.valid !== 1'b1 || bus.reg_sel !== exp_81[1] || bus.count !== 4'd1) begin
      errors++;
      $display("FAIL stall_second got v%b sel%0d cnt%0d want v1 sel%0d cnt1",
               bus.valid, bus.reg_sel, bus.count, exp_81[1]);
    end
    step();
    bus.advance = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.count !== 4'd2) begin
      errors++;
      $display("FAIL stall_done got d%b cnt%0d want d1 cnt2", bus.done, bus.count);
    end
    step();
  endtask

  task automatic test_zero_mask();
    bus.imm = 8'h00; bus.start = 1'b1; bus.advance = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.valid !== 1'b0 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL zero_done got d%b b%b v%b cnt%0d want d1 b1 v0 cnt0",
               bus.done, bus.busy, bus.valid, bus.count);
    end
    step();
    bus.advance = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_after got d%b b%b v%b want d0 b0 v0", bus.done, bus.busy, bus.valid);
    end
  endtask

  task automatic test_start_while_busy();
    bus.imm = 8'h0F; bus.start = 1'b1; bus.advance = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.reg_sel !== exp_0f[i]) begin
        errors++;
        $display("FAIL busy_xfer%0d got v%b sel%0d want v1 sel%0d", i, bus.valid, bus.reg_sel, exp_0f[i]);
      end
      if (i == 1) begin bus.start = 1'b1; bus.imm = 8'hF0; end
      else bus.start = 1'b0;
      step();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.count !== 4'd4) begin
      errors++;
      $display("FAIL busy_done got d%b cnt%0d want d1 cnt4", bus.done, bus.count);
    end
    // start during the DONE cycle must be dropped
    bus.start = 1'b1; bus.imm = 8'h01; bus.advance = 1'b0;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.count !== 4'd4) begin
      errors++;
      $display("FAIL done_start_ignored got b%b v%b cnt%0d want b0 v0 cnt4", bus.busy, bus.valid, bus.count);
    end
  endtask

  task automatic test_full_mask();
    bus.imm = 8'hFF; bus.start = 1'b1; bus.advance = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.reg_sel !== exp_ff[i] || bus.count !== 4'(i)) begin
        errors++;
        $display("FAIL full_xfer%0d got v%b sel%0d cnt%0d want v1 sel%0d cnt%0d",
                 i, bus.valid, bus.reg_sel, bus.count, exp_ff[i], i);
      end
      step();
    end
    bus.advance = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.count !== 4'd8) begin
      errors++;
      $display("FAIL full_done got d%b cnt%0d want d1 cnt8", bus.done, bus.count);
    end
    step();
  endtask

  task automatic test_flush();
    bus.imm = 8'hFF; bus.start = 1'b1; bus.advance = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    checks++;
    if (bus.reg_sel !== exp_ff[2] || bus.count !== 4'd2) begin
      errors++;
      $display("FAIL flush_pre got sel%0d cnt%0d want sel%0d cnt2", bus.reg_sel, bus.count, exp_ff[2]);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL flush_idle got v%b b%b d%b cnt%0d want v0 b0 d0 cnt0",
               bus.valid, bus.busy, bus.done, bus.count);
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_done got d%b b%b want d0 b0", bus.done, bus.busy);
    end
    // flush outranks start in the same cycle
    bus.imm = 8'h01; bus.start = 1'b1; bus.flush = 1'b1;
    step();
    bus.start = 1'b0; bus.flush = 1'b0; bus.advance = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_start got b%b v%b want b0 v0", bus.busy, bus.valid);
    end
  endtask

  task automatic test_async_reset();
    bus.imm = 8'hFF; bus.start = 1'b1; bus.advance = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.valid, bus.busy, bus.done, bus.reg_sel, bus.count} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset got v%b b%b d%b sel%0d cnt%0d want all zero",
               bus.valid, bus.busy, bus.done, bus.reg_sel, bus.count);
    end
    #1;
    reset = 1'b1;
    bus.advance = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle got b%b d%b v%b want b0 d0 v0", bus.busy, bus.done, bus.valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ascend();
    test_stall();
    test_zero_mask();
    test_start_while_busy();
    test_full_mask();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Register-list sequencer for load-multiple / store-multiple instructions. It accepts an 8-bit register mask from the instruction immediate and emits one 3-bit register index per transfer, lowest set bit first. The index goes straight into the `decode8` select input of the register-file write-enable path. A running transfer count drives the memory address offset. It sits between the control FSM, which starts it and acknowledges transfers, and the register-file decoder.

## Interface
- No parameters; the width is fixed at 8 registers, 3-bit index.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `start` in 1: begin a sequence with `imm`; honoured only in IDLE.
- `imm` in 8: register list; bit i set means register i is transferred.
- `advance` in 1: consumer has completed the current transfer; honoured only while `valid`.
- `flush` in 1: synchronous abort to IDLE.
- `reg_sel` out 3: current register index, to `decode8`.
- `valid` out 1: `reg_sel` holds a live transfer.
- `busy` out 1: sequencer is in RUN or DONE.
- `done` out 1: one-cycle pulse when the sequence finishes normally.
- `count` out 4: transfers completed in this sequence, 0..8.

## Operation
- Internal state: FSM {IDLE, RUN, DONE}, 8-bit `pending` mask, 4-bit `count`.
- Reset values: state IDLE, `pending`=0, `count`=0, `reg_sel`=0, `valid`=0, `busy`=0, `done`=0.
- IDLE + `start`:
  - Load `pending`←`imm` and clear `count`←0.
  - Go to RUN if `imm`≠0, or to DONE if `imm`=0. A zero mask produces no valid cycle.
- In any state other than IDLE, `start` is ignored, and `imm` is don't-care.
- RUN:
  - `valid`=1.
  - `reg_sel` is a combinational priority encode of the registered `pending`, lowest set bit first.
  - `advance` with `valid`: clear bit `reg_sel` of `pending` and increment `count`.
  - If that advance clears the last set bit, go to DONE; otherwise stay in RUN.
  - Without `advance`, everything holds, so `reg_sel` stays stable through a stall.
- DONE: `done`=1 and `busy`=1 for exactly one cycle, `valid`=0, then return to IDLE. `count` holds its final value until the next accepted `start`.
- `flush`:
  - In any state, next state is IDLE with `pending`←0 and `count`←0.
  - No `done` pulse is produced.
  - `flush` takes priority over `start` and `advance` in the same cycle.
- `reg_sel`:
  - Equals 0 whenever `valid`=0.
  - Only meaningful while `valid`=1; `decode8` output must be qualified by `valid` downstream.
- `count` never exceeds 8 (at most 8 advances per sequence), so no wrap-around logic is needed.
- `busy` = (state≠IDLE).

## Timing
- `start` sampled at edge N → `valid` and the first `reg_sel` appear in cycle N+1 (1-cycle latency).
- Each `advance` sampled at edge k → the next index, or DONE, appears in cycle k+1.
- Throughput is one transfer per cycle with `advance` held high.
- An n-bit mask with continuous `advance` gives:
  - `valid` for cycles N+1..N+n;
  - `done` in cycle N+n+1;
  - IDLE, ready for `start`, at cycle N+n+2.
- Zero mask → `done` in cycle N+1.
- A `start` asserted during the DONE cycle is ignored. The earliest accepted restart is the cycle after `done`.
- `reset` low mid-sequence: all outputs drop to their reset values asynchronously, with no `done` pulse. After release the block is in IDLE.

## Configuration
- Macro `LM_SEQ_DESCEND_EN`.
  - Defined: the priority encoder selects the highest set bit first (descending order, for stack-style transfers).
  - Undefined (default): lowest set bit first.
- Nothing else changes: latency, `count`, `done` and `flush` are identical in both builds.

## Test plan
- Ascending sequence with no stall:
  - Stimulus: `imm`=8'b1010_0101, `start` at N, `advance` held 1.
  - Response: `reg_sel`=0,2,5,7 in cycles N+1..N+4; `count` at those cycles 0,1,2,3; `done` at N+5; `count`=4 afterwards.
- Stall:
  - Stimulus: `imm`=8'h81, `advance` low for 3 cycles after `start`, then high.
  - Response: `reg_sel`=0 and `valid`=1 held for the 3 stall cycles, then 7, then `done`; `count`=2.
- Zero mask:
  - Stimulus: `imm`=0, `start`.
  - Response: `valid` never asserts; `done`=1 in cycle N+1; `busy`=1 for that cycle only; `count`=0.
- Start while busy:
  - Stimulus: `imm`=8'h0F running; second `start` with `imm`=8'hF0 at the second valid cycle.
  - Response: sequence continues with 2, 3 and completes with `count`=4; 8'hF0 is never loaded.
- Flush and reset mid-sequence:
  - Stimulus 1: `imm`=8'hFF, `flush` at the third valid cycle.
  - Response 1: next cycle IDLE, `valid`=0, `count`=0, no `done`.
  - Stimulus 2: repeat with `reset` pulsed low instead of `flush`.
  - Response 2: outputs go to 0 during the low pulse itself.
- Descending build:
  - Stimulus: `imm`=8'b1010_0101 with `LM_SEQ_DESCEND_EN` defined.
  - Response: `reg_sel`=7,5,2,0; `done` at N+5.
